hazard_stall_ctrl: RTL

Consumer side of the hazard detection signals in the 5-stage pipeline. Takes the data-hazard and branch-hazard flags raised for the instruction in decode and turns them into pipeline control: PC hold, IF/ID hold, ID/EX bubble insert and IF/ID flush. Holds each stall or branch-shadow for a counted number of cycles, so a one-cycle hazard pulse still gets its full stall. Sits between the hazard detector outputs and the PC/IF-ID/ID-EX pipeline registers.

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_stall_ctrl_stall_counter.sv | 36 +++
 rtl/hazard_stall_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared state encoding, default stall latencies and NOP encoding
//          for the decode-stage hazard stall controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DSTALL = 2'd1;
    localparam logic [1:0] BWAIT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_DSTALL = DSTALL,
        ST_BWAIT  = BWAIT
    } hazard_state_e;

    localparam int c_def_data_stall_ex  = 2;
    localparam int c_def_data_stall_mem = 1;
    localparam int c_def_branch_lat     = 2;
    localparam int c_def_cnt_w          = 2;

    // addi x0, x0, 0 -- what the pipeline registers load for a bubble/flush
    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/hazard_stall_ctrl_stall_counter.sv
// ============================================================================
// Module : stall_counter
// Brief  : Remaining-cycle down-counter with load, decrement and is_one flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stall_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one
);

    logic [CNT_W-1:0] r_cnt;

    // Decrement floors at 1 so the count never wraps inside a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt > CNT_W'(1))) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign is_one = (r_cnt == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module : hazard_stall_ctrl
// Brief  : Turns decode-stage data/branch hazard flags into PC hold, IF/ID
//          hold, ID/EX bubble and IF/ID flush, each held for a counted span.
//          Optional HAZARD_STALL_STATS_EN adds stall/flush cycle counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int DATA_STALL_EX  = c_def_data_stall_ex,
    parameter int DATA_STALL_MEM = c_def_data_stall_mem,
    parameter int BRANCH_LAT     = c_def_branch_lat,
    parameter int CNT_W          = c_def_cnt_w
) (
    input  logic clk,
    input  logic rst,
    input  logic data_haz_s1,
    input  logic data_haz_s2,
    input  logic branch_haz,
    input  logic branch_resolved,
    output logic pc_write_en,
    output logic if_id_write_en,
    output logic id_ex_bubble,
    output logic if_id_flush,
    output logic stall_active
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [15:0] data_stall_cycles,
    output logic [15:0] branch_flush_cycles
`endif
);

    localparam int c_cnt_max = 1 << CNT_W;
    localparam logic [CNT_W-1:0] c_ex_load  = CNT_W'(DATA_STALL_EX - 1);
    localparam logic [CNT_W-1:0] c_mem_load = CNT_W'(DATA_STALL_MEM - 1);
    localparam logic [CNT_W-1:0] c_br_load  = CNT_W'(BRANCH_LAT - 1);

    generate
        if ((DATA_STALL_EX < 1) || (DATA_STALL_EX > c_cnt_max) ||
            (DATA_STALL_MEM < 1) || (DATA_STALL_MEM > c_cnt_max) ||
            (BRANCH_LAT < 1) || (BRANCH_LAT > c_cnt_max) || (CNT_W < 1)) begin : g_param_check
            $error("hazard_stall_ctrl: stall latency parameter out of range 1..2^CNT_W");
        end
    endgenerate

    hazard_state_e    r_state;
    hazard_state_e    w_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_is_one;

    stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .dec      (w_dec),
        .is_one   (w_is_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // IDLE outputs follow the hazard inputs directly so a stall costs no
    // detection cycle; the counted states drive fixed Moore outputs.
    always_comb begin
        w_next         = r_state;
        w_load         = 1'b0;
        w_load_val     = '0;
        w_dec          = 1'b0;
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        id_ex_bubble   = 1'b0;
        if_id_flush    = 1'b0;
        stall_active   = 1'b0;
        if (rst) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (data_haz_s2 || data_haz_s1) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_bubble   = 1'b1;
                        stall_active   = 1'b1;
                        if (data_haz_s2 && (DATA_STALL_EX > 1)) begin
                            w_load     = 1'b1;
                            w_load_val = c_ex_load;
                            w_next     = ST_DSTALL;
                        end else if (!data_haz_s2 && (DATA_STALL_MEM > 1)) begin
                            w_load     = 1'b1;
                            w_load_val = c_mem_load;
                            w_next     = ST_DSTALL;
                        end
                    end else if (branch_haz) begin
                        pc_write_en  = 1'b0;
                        if_id_flush  = 1'b1;
                        stall_active = 1'b1;
                        if (BRANCH_LAT > 1) begin
                            w_load     = 1'b1;
                            w_load_val = c_br_load;
                            w_next     = ST_BWAIT;
                        end
                    end
                end
                ST_DSTALL: begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                    stall_active   = 1'b1;
                    if (w_is_one) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                ST_BWAIT: begin
                    pc_write_en  = 1'b0;
                    if_id_flush  = 1'b1;
                    stall_active = 1'b1;
                    if (branch_resolved || w_is_one) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_STATS_EN
    logic [15:0] r_data_stall_cycles;
    logic [15:0] r_branch_flush_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_stall_cycles   <= '0;
            r_branch_flush_cycles <= '0;
        end else begin
            if (id_ex_bubble && (r_data_stall_cycles != 16'hFFFF)) begin
                r_data_stall_cycles <= r_data_stall_cycles + 16'd1;
            end
            if (if_id_flush && (r_branch_flush_cycles != 16'hFFFF)) begin
                r_branch_flush_cycles <= r_branch_flush_cycles + 16'd1;
            end
        end
    end

    assign data_stall_cycles   = r_data_stall_cycles;
    assign branch_flush_cycles = r_branch_flush_cycles;
`endif

endmodule

`default_nettype wire
